// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   CNT_W     : width of the wait-state counter
//   F3_*      : funct3 access-size codes
//   state_e   : responder FSM states
//   size_e    : decoded access size
//   mem_req_t : latched request payload
package mem_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane placement and alignment/funct3 checking.
//   addr_lo_i      : byte offset within the word
//   funct3_i, we_i : access size/type and direction
//   wdata_i        : right-justified store data
//   rword_i        : raw word read from the array
//   byte_en_c_o    : lanes to write (zero on any alignment/funct3 error)
//   wdata_c_o      : store data shifted into its lanes
//   rdata_c_o      : load data right-justified, zero-extended
//   err_align_c_o  : misaligned half/word access
//   err_funct3_c_o : funct3 not legal for this direction
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byte_en_c_o,
   output logic [31:0] wdata_c_o,
   output logic [31:0] rdata_c_o,
   output logic        err_align_c_o,
   output logic        err_funct3_c_o
);

   size_e       size_c;
   logic        illegal_c;
   logic        misal_c;
   logic [3:0]  base_en_c;
   logic [31:0] mask_c;
   logic [4:0]  shamt_c;

   // Size decode; unsigned variants exist only for loads
   always_comb begin
      size_c    = SZ_B;
      illegal_c = 1'b0;
      case (funct3_i)
         F3_B:    size_c = SZ_B;
         F3_H:    size_c = SZ_H;
         F3_W:    size_c = SZ_W;
         F3_BU:   begin size_c = SZ_B; illegal_c = we_i; end
         F3_HU:   begin size_c = SZ_H; illegal_c = we_i; end
         default: illegal_c = 1'b1;
      endcase
   end

   // Lane placement and extraction
   always_comb begin
      misal_c   = ((size_c == SZ_H) && addr_lo_i[0]) ||
                  ((size_c == SZ_W) && (addr_lo_i != 2'b00));
      base_en_c = 4'b1111;
      mask_c    = 32'hFFFF_FFFF;
      case (size_c)
         SZ_B: begin base_en_c = 4'b0001; mask_c = 32'h0000_00FF; end
         SZ_H: begin base_en_c = 4'b0011; mask_c = 32'h0000_FFFF; end
         default: ;
      endcase
      shamt_c        = {addr_lo_i, 3'b000};
      byte_en_c_o    = (illegal_c || misal_c) ? 4'b0000 : (base_en_c << addr_lo_i);
      wdata_c_o      = wdata_i << shamt_c;
      rdata_c_o      = (rword_i >> shamt_c) & mask_c;
      err_align_c_o  = misal_c;
      err_funct3_c_o = illegal_c;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// word-organised RAM with byte/half/word lane access.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/req_ready_o: request handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_funct3_i, req_wdata_i : request payload
//   rsp_valid_o/rsp_ready_i: response handshake, held until taken
//   rsp_rdata_o, rsp_err_o : right-justified load data, error flag
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
   localparam int unsigned TAG_LSB = IDX_W + 2;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_req_t         req_q, req_d;

   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   mem_req_t         req_in_c;
   mem_req_t         acc_c;
   logic             acc_en_c;
   logic             err_range_c;
   logic             err_align_c;
   logic             err_funct3_c;
   logic             err_c;
   logic [IDX_W-1:0] widx_c;
   logic [31:0]      rword_c;
   logic [3:0]       byte_en_c;
   logic [31:0]      wdata_sh_c;
   logic [31:0]      rdata_c;

   // Access path: with no wait states the array sees the live request on the
   // accept edge, otherwise the latched copy on the last BUSY edge.
   always_comb begin
      req_in_c.we     = req_we_i;
      req_in_c.funct3 = req_funct3_i;
      req_in_c.addr   = req_addr_i;
      req_in_c.wdata  = req_wdata_i;
      acc_c           = (state_q == IDLE) ? req_in_c : req_q;
      acc_en_c        = ((state_q == IDLE) && req_valid_i && (WAIT_CYCLES == 0)) ||
                        ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
      err_range_c     = |(acc_c.addr >> TAG_LSB);
      err_c           = err_range_c | err_align_c | err_funct3_c;
   end

   assign widx_c  = acc_c.addr[IDX_W+1:2];
   assign rword_c = mem_q[widx_c];

   mem_lane_align u_align (
      .addr_lo_i      (acc_c.addr[1:0]),
      .funct3_i       (acc_c.funct3),
      .we_i           (acc_c.we),
      .wdata_i        (acc_c.wdata),
      .rword_i        (rword_c),
      .byte_en_c_o    (byte_en_c),
      .wdata_c_o      (wdata_sh_c),
      .rdata_c_o      (rdata_c),
      .err_align_c_o  (err_align_c),
      .err_funct3_c_o (err_funct3_c)
   );

   // Array write: only enabled lanes of a fault-free store
   always_ff @(posedge clk_i) begin
      if (acc_en_c && acc_c.we && !err_c) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_c[b]) begin
               mem_q[widx_c][8*b +: 8] <= wdata_sh_c[8*b +: 8];
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               req_d = req_in_c;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; response fields freeze until taken
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (acc_en_c) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = (err_c || acc_c.we) ? 32'h0 : rdata_c;
         rsp_err_d   = err_c;
      end else if ((state_q == RESP) && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
         rsp_rdata_d = 32'h0;
         rsp_err_d   = 1'b0;
      end
      req_ready_d = (state_d == IDLE);
   end

   // Output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level memory model, plus literal checks.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [2:0]  req_f3    [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int errors = 0;
   int checks = 0;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_we_i(req_we[0]), .req_addr_i(req_addr[0]),
      .req_funct3_i(req_f3[0]), .req_wdata_i(req_wdata[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_we_i(req_we[1]), .req_addr_i(req_addr[1]),
      .req_funct3_i(req_f3[1]), .req_wdata_i(req_wdata[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mdl [2][DEPTH];
   int          phase [2] = '{0, 0};   // 0 idle, 1 waiting, 2 responding
   int unsigned acc_edge [2];
   int unsigned edge_n = 0;
   logic        m_we [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd [2];
   logic [2:0]  m_f3 [2];
   logic [31:0] exp_rd [2];
   logic        exp_er [2];

   function automatic void model_access(input int k);
      int unsigned a;
      int unsigned sz;
      int unsigned off;
      bit          legal;
      logic [31:0] w;
      a     = m_addr[k];
      sz    = 1;
      legal = 1'b1;
      case (m_f3[k])
         3'd0: sz = 1;
         3'd1: sz = 2;
         3'd2: sz = 4;
         3'd4: begin sz = 1; legal = !m_we[k]; end
         3'd5: begin sz = 2; legal = !m_we[k]; end
         default: legal = 1'b0;
      endcase
      exp_rd[k] = 32'h0;
      if (!legal || (a % sz) != 0 || a >= 4 * DEPTH) begin
         exp_er[k] = 1'b1;
         return;
      end
      exp_er[k] = 1'b0;
      off = a % 4;
      w   = mdl[k][a / 4];
      for (int unsigned b = 0; b < sz; b++) begin
         if (m_we[k]) w[8*(off+b) +: 8] = m_wd[k][8*b +: 8];
         else         exp_rd[k][8*b +: 8] = w[8*(off+b) +: 8];
      end
      if (m_we[k]) mdl[k][a / 4] = w;
   endfunction

   // Model advances on each rising edge
   initial forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst_n[k] !== 1'b1) begin
            phase[k] = 0;
         end else begin
            case (phase[k])
               0: if (req_valid[k]) begin
                  m_we[k]     = req_we[k];
                  m_addr[k]   = req_addr[k];
                  m_wd[k]     = req_wdata[k];
                  m_f3[k]     = req_f3[k];
                  acc_edge[k] = edge_n;
                  if (wait_of(k) == 0) begin
                     model_access(k);
                     phase[k] = 2;
                  end else begin
                     phase[k] = 1;
                  end
               end
               1: if (edge_n == acc_edge[k] + wait_of(k)) begin
                  model_access(k);
                  phase[k] = 2;
               end
               default: if (rsp_ready[k]) phase[k] = 0;
            endcase
         end
      end
      edge_n++;
   end

   // Compare process: every falling edge while out of reset
   initial forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst_n[k] === 1'b1) begin
            chk($sformatf("d%0d req_ready", k), 32'(req_ready[k]), 32'(phase[k] == 0));
            chk($sformatf("d%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(phase[k] == 2));
            if (phase[k] == 2) begin
               chk($sformatf("d%0d rsp_rdata", k), rsp_rdata[k], exp_rd[k]);
               chk($sformatf("d%0d rsp_err", k), 32'(rsp_err[k]), 32'(exp_er[k]));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input int hold, input bit junk,
                         output logic [31:0] rd, output logic er, output int lat);
      int  n;
      time t_acc;
      rd  = 32'h0;
      er  = 1'b0;
      lat = -1;
      n   = 0;
      while (!req_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[k]) begin
         chk($sformatf("d%0d accept timeout", k), 32'(req_ready[k]), 32'd1);
         return;
      end
      rsp_ready[k] = (hold == 0);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_f3[k]    = f3;
      req_wdata[k] = wd;
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      req_valid[k] = 1'b0;
      n = 0;
      while (!rsp_valid[k] && n < 50) begin
         if (junk) begin
            req_valid[k] = 1'b1;
            req_we[k]    = 1'($urandom);
            req_addr[k]  = $urandom;
            req_f3[k]    = 3'($urandom);
            req_wdata[k] = $urandom;
         end
         @(negedge clk);
         n++;
      end
      req_valid[k] = 1'b0;
      if (!rsp_valid[k]) begin
         chk($sformatf("d%0d response timeout", k), 32'(rsp_valid[k]), 32'd1);
         return;
      end
      lat = int'(($time - t_acc - 5) / 10) + 1;
      rd  = rsp_rdata[k];
      er  = rsp_err[k];
      repeat (hold) @(negedge clk);
      rsp_ready[k] = 1'b1;
      @(negedge clk);
   endtask

   task automatic lit(input int k, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd, input int hold,
                      input logic [31:0] e_rd, input logic e_er, input int e_lat,
                      input string name);
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(k, we, addr, f3, wd, hold, 1'b0, rd, er, lat);
      chk({name, " rdata"}, rd, e_rd);
      chk({name, " err"}, 32'(er), 32'(e_er));
      if (e_lat >= 0) chk({name, " latency"}, 32'(lat), 32'(e_lat));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, wd, addr;
      logic        er, we;
      logic [2:0]  f3;
      int          lat;
      for (int k = 0; k < 2; k++) begin
         rst_n[k]     = 1'b1;
         req_valid[k] = 1'b0;
         req_we[k]    = 1'b0;
         req_addr[k]  = 32'h0;
         req_f3[k]    = 3'd0;
         req_wdata[k] = 32'h0;
         rsp_ready[k] = 1'b0;
      end
      #1;
      rst_n[0] = 1'b0;
      rst_n[1] = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d reset req_ready", k), 32'(req_ready[k]), 32'd1);
         chk($sformatf("d%0d reset rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
         chk($sformatf("d%0d reset rsp_rdata", k), rsp_rdata[k], 32'h0);
         chk($sformatf("d%0d reset rsp_err", k), 32'(rsp_err[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);

      // Zero wait states: basic lane tests
      lit(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1, "SW 0x10");
      lit(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1, "LW 0x10");
      lit(0, 1'b1, 32'h11, 3'd0, 32'h000000AA, 0, 32'h0, 1'b0, -1, "SB 0x11");
      lit(0, 1'b0, 32'h11, 3'd4, 32'h0, 0, 32'h000000AA, 1'b0, -1, "LBU 0x11");
      lit(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADAAEF, 1'b0, -1, "LW after SB");
      lit(0, 1'b1, 32'h12, 3'd1, 32'h00001234, 0, 32'h0, 1'b0, -1, "SH 0x12");
      lit(0, 1'b0, 32'h12, 3'd5, 32'h0, 0, 32'h00001234, 1'b0, -1, "LHU 0x12");
      lit(0, 1'b0, 32'h10, 3'd0, 32'h0, 0, 32'h000000EF, 1'b0, -1, "LB 0x10 zero-fill");
      lit(0, 1'b0, 32'h13, 3'd0, 32'h0, 0, 32'h00000012, 1'b0, -1, "LB 0x13");
      lit(0, 1'b0, 32'h12, 3'd2, 32'h0, 0, 32'h0, 1'b1, 1, "LW 0x12 misaligned");
      lit(0, 1'b1, 32'h13, 3'd1, 32'h00005678, 0, 32'h0, 1'b1, -1, "SH 0x13 misaligned");
      lit(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 32'h1234AAEF, 1'b0, -1, "LW unchanged");
      lit(0, 1'b0, 4 * DEPTH, 3'd2, 32'h0, 0, 32'h0, 1'b1, -1, "LW out of range");
      lit(0, 1'b0, 32'h10, 3'd3, 32'h0, 0, 32'h0, 1'b1, -1, "load funct3 011");
      lit(0, 1'b1, 32'h10, 3'd4, 32'hFFFFFFFF, 0, 32'h0, 1'b1, -1, "store funct3 100");
      lit(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 32'h1234AAEF, 1'b0, -1, "LW no illegal write");

      // Three wait states with back-pressure
      lit(1, 1'b1, 32'h10, 3'd2, 32'hCAFEF00D, 0, 32'h0, 1'b0, 4, "w3 SW 0x10");
      lit(1, 1'b0, 32'h10, 3'd2, 32'h0, 5, 32'hCAFEF00D, 1'b0, 4, "w3 LW held");

      // Reset during BUSY aborts the store
      lit(1, 1'b1, 32'h20, 3'd2, 32'h0, 0, 32'h0, 1'b0, -1, "w3 SW 0x20 init");
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h20;
      req_f3[1]    = 3'd2;
      req_wdata[1] = 32'h11111111;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n[1] = 1'b0;
      #1;
      chk("abort req_ready", 32'(req_ready[1]), 32'd1);
      chk("abort rsp_valid", 32'(rsp_valid[1]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n[1] = 1'b1;
      @(negedge clk);
      lit(1, 1'b0, 32'h20, 3'd2, 32'h0, 0, 32'h0, 1'b0, 4, "w3 LW after abort");

      // Randomized traffic on words 0..7, occasionally out of range
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 8; w++) begin
            do_req(k, 1'b1, 32'(4 * w), 3'd2, $urandom, 0, 1'b0, rd, er, lat);
         end
         repeat (120) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               4: f3 = 3'd5;
               default: f3 = 3'($urandom);
            endcase
            addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_1000)
                                               : 32'($urandom_range(0, 31));
            wd = $urandom;
            if (f3 == 3'd0) wd = wd & 32'h0000_00FF;
            if (f3 == 3'd1) wd = wd & 32'h0000_FFFF;
            do_req(k, we, addr, f3, wd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   rd, er, lat);
         end
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
